vga_scanout: RTL and testbench
==============================

# vga_scanout

Pixel-stream sink and VGA timing generator at the display end of the video pipeline. It accepts raster-ordered pixels (x, y, color index) from the compositor through a valid/ready handshake and buffers them in a two-line ping-pong buffer. It generates 640x480@60 VGA sync and blank timing and drives the buffered color indices out in step with the active region. Mapping color indices to DAC levels is done downstream.

## Interface
- WIDTH, 640: active pixels per line
- HEIGHT, 480: active lines per frame
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths, in pixel ticks
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths, in lines
- CLK_DIV, 2: clk cycles per pixel tick (>=1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel offered
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_x  in  $clog2(WIDTH)  pixel column
- in_y  in  $clog2(HEIGHT)  pixel row
- in_color  in  COLOR_WIDTH  color index
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_blank  out  1  1 outside the active region
- vga_color  out  COLOR_WIDTH  color index; 0 when blanked
- underrun  out  1  sticky: a line was needed before it was fully written
- seq_err  out  1  sticky: an out-of-order pixel was dropped

## Operation
- Pixel tick:
  - Divider counts 0..CLK_DIV-1.
  - A tick occurs on the clk where divider == CLK_DIV-1.
  - The display side advances only on ticks. The write side runs every clk.
- Counters:
  - h counts 0..H_TOTAL-1, with H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (800).
  - v increments when h wraps, counting 0..V_TOTAL-1 (525).
  - v wraps to 0 after V_TOTAL-1.
- Regions:
  - Active when h<WIDTH and v<HEIGHT.
  - hsync low for h in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC), i.e. [656,752).
  - vsync low for v in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC), i.e. [490,492).
- Buffers:
  - Two banks of WIDTH entries each. Row r always lives in bank r[0].
  - Flags full[1:0] record which banks hold a complete line.
- Writer:
  - Keeps the expected position (wx, wy).
  - in_ready = !full[wy[0]] && !resync.
  - On acceptance with in_x==wx and in_y==wy:
    - Write in_color to bank wy[0], address wx.
    - If wx==WIDTH-1: set full[wy[0]], wx←0, wy←wy+1, with wy wrapping HEIGHT-1→0.
    - Otherwise wx←wx+1.
  - On acceptance with a mismatched position: drop the pixel, set seq_err, leave wx and wy unchanged.
- Reader:
  - At h==0 of active line v:
    - If full[v[0]]: display the line from bank v[0].
    - Otherwise: set underrun and resync.
  - At the tick with h==WIDTH-1 of a displayed line, clear full[v[0]].
- Resync:
  - While resync is set, remaining active pixels of the frame output 0 and in_ready=0.
  - At the tick with v==HEIGHT, h==0: clear full[1:0], set wx=wy=0, clear resync.
- Simultaneous set and clear of the same bank cannot occur: the writer sets only an empty bank and the reader clears only a full one.
- No arithmetic overflow: all counters compare against their terminal value before wrapping.

## Timing
- Reset values:
  - h=v=0, divider=0, wx=wy=0, full=0, resync=0.
  - vga_hsync=1, vga_vsync=1, vga_blank=1, vga_color=0.
  - underrun=0, seq_err=0.
  - in_ready=1 in the first cycle after reset.
- Display outputs are registered and update on ticks.
- Outputs reflect the (h, v) of the previous tick, so latency is 1 pixel tick: pixel (x, y) appears on the tick after h==x, v==y.
- Writer acceptance:
  - Buffer write and flag update take effect on the accepting clk edge.
  - in_ready reflects the new flags on the next clk.
- The writer may run up to two lines ahead of the display. Rows 0 and 1 are prefilled during vertical blanking.
- Reset mid-frame or mid-line abandons all buffered data and restarts at h=v=0.
- Sticky flags clear only on reset.

## Test plan
- Reset: assert reset for 3 clk → all outputs at the reset values listed in Timing; in_ready=1.
- Sync timing, CLK_DIV=1, no input:
  - vga_hsync low for exactly 96 ticks starting at tick 656 of each line.
  - Line period is 800 ticks.
  - vga_vsync low for 1600 ticks starting at line 490.
  - underrun=1 at the first active line.
- Data path, WIDTH=8, HEIGHT=4, CLK_DIV=2:
  - Stream all rows in raster order with color = x+y*8 while the display is in blanking.
  - During the next frame, vga_color on the tick after h==x, v==y equals x+y*8.
  - underrun stays 0.
- Backpressure, default params, display held in reset after 2 lines written:
  - in_ready falls after exactly 1280 accepted pixels.
  - It rises in the clk after the reader clears bank 0 (tick with h==639, v==0).
- Sequence error: with the expected position (0,0), offer in_x=5, in_y=0 → pixel consumed, seq_err=1, wx=0, nothing written.
- Underrun recovery:
  - No input until v=2, then stream continuously.
  - underrun=1 at v=0, h=0; in_ready=0.
  - vga_color=0 for the whole frame.
  - in_ready=1 after the tick with v==480, h==0.
  - The next frame displays correct data.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: pixel-stream sink and 640x480@60 VGA timing generator.
//
// Raster-ordered pixels arrive over a valid/ready handshake and are stored in a
// two-line ping-pong buffer (row r lives in bank r[0]). The display side walks
// the VGA raster one pixel tick every CLK_DIV clocks and replays buffered lines
// during the active region. Color indices are mapped to DAC levels downstream.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   pixel offered
//   in_ready   pixel accepted when in_valid && in_ready
//   in_x       pixel column
//   in_y       pixel row
//   in_color   color index
//   vga_hsync  horizontal sync, active low
//   vga_vsync  vertical sync, active low
//   vga_blank  1 outside the active region
//   vga_color  color index, 0 when blanked
//   underrun   sticky: a line was needed before it was fully written
//   seq_err    sticky: an out-of-order pixel was dropped
module vga_scanout #(
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned COLOR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [$clog2(WIDTH)-1:0]   in_x,
   input  logic [$clog2(HEIGHT)-1:0]  in_y,
   input  logic [COLOR_WIDTH-1:0]     in_color,
   output logic                       vga_hsync,
   output logic                       vga_vsync,
   output logic                       vga_blank,
   output logic [COLOR_WIDTH-1:0]     vga_color,
   output logic                       underrun,
   output logic                       seq_err
);

   localparam int unsigned H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned XW      = $clog2(WIDTH);
   localparam int unsigned YW      = $clog2(HEIGHT);
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // Raster state
   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;

   // Writer state
   logic [XW-1:0] wx_q, wx_d;
   logic [YW-1:0] wy_q, wy_d;
   logic [1:0]    full_q, full_d;
   logic          resync_q, resync_d;
   logic          line_ok_q, line_ok_d;

   // Registered outputs
   logic                   hsync_q, hsync_d;
   logic                   vsync_q, vsync_d;
   logic                   blank_q, blank_d;
   logic [COLOR_WIDTH-1:0] color_q, color_d;
   logic                   underrun_q, underrun_d;
   logic                   seq_err_q, seq_err_d;

   logic [COLOR_WIDTH-1:0] line_mem [2][WIDTH];
   logic [COLOR_WIDTH-1:0] rd_color;

   logic tick;
   logic active;
   logic line_start;
   logic show;
   logic resync_done;
   logic accept;
   logic in_order;
   logic wr_en;

   assign tick        = (div_q == DW'(CLK_DIV - 1));
   assign active      = (h_q < HW'(WIDTH)) && (v_q < VW'(HEIGHT));
   assign line_start  = tick && active && (h_q == '0);
   // At h==0 the line decision is made from the live flag; afterwards the
   // decision latched at line start holds for the rest of the line.
   assign show        = active && !resync_q && ((h_q == '0) ? full_q[v_q[0]] : line_ok_q);
   assign resync_done = tick && resync_q && (v_q == VW'(HEIGHT)) && (h_q == '0);

   assign in_ready = !full_q[wy_q[0]] && !resync_q;
   assign accept   = in_valid && in_ready;
   assign in_order = (in_x == wx_q) && (in_y == wy_q);
   assign wr_en    = accept && in_order;

   assign rd_color = line_mem[v_q[0]][h_q[XW-1:0]];

   // Raster counters
   always_comb begin
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         div_d = '0;
         if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == VW'(V_TOTAL - 1)) begin
               v_d = '0;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // Writer position, bank flags and resync
   always_comb begin
      wx_d       = wx_q;
      wy_d       = wy_q;
      full_d     = full_q;
      resync_d   = resync_q;
      line_ok_d  = line_ok_q;
      underrun_d = underrun_q;
      seq_err_d  = seq_err_q;

      if (accept) begin
         if (in_order) begin
            if (wx_q == XW'(WIDTH - 1)) begin
               full_d[wy_q[0]] = 1'b1;
               wx_d            = '0;
               if (wy_q == YW'(HEIGHT - 1)) begin
                  wy_d = '0;
               end else begin
                  wy_d = wy_q + 1'b1;
               end
            end else begin
               wx_d = wx_q + 1'b1;
            end
         end else begin
            seq_err_d = 1'b1;
         end
      end

      if (line_start) begin
         line_ok_d = !resync_q && full_q[v_q[0]];
         if (!resync_q && !full_q[v_q[0]]) begin
            underrun_d = 1'b1;
            resync_d   = 1'b1;
         end
      end

      // Last pixel of a displayed line frees its bank for the writer.
      if (tick && show && (h_q == HW'(WIDTH - 1))) begin
         full_d[v_q[0]] = 1'b0;
      end

      // Restart the writer at the top of the next frame.
      if (resync_done) begin
         full_d   = '0;
         wx_d     = '0;
         wy_d     = '0;
         resync_d = 1'b0;
      end
   end

   // Display outputs, computed from the current raster position
   always_comb begin
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      blank_d = blank_q;
      color_d = color_q;
      if (tick) begin
         hsync_d = !((h_q >= HW'(WIDTH + H_FP)) && (h_q < HW'(WIDTH + H_FP + H_SYNC)));
         vsync_d = !((v_q >= VW'(HEIGHT + V_FP)) && (v_q < VW'(HEIGHT + V_FP + V_SYNC)));
         blank_d = !active;
         color_d = show ? rd_color : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= '0;
         h_q        <= '0;
         v_q        <= '0;
         wx_q       <= '0;
         wy_q       <= '0;
         full_q     <= '0;
         resync_q   <= 1'b0;
         line_ok_q  <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         blank_q    <= 1'b1;
         color_q    <= '0;
         underrun_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         div_q      <= div_d;
         h_q        <= h_d;
         v_q        <= v_d;
         wx_q       <= wx_d;
         wy_q       <= wy_d;
         full_q     <= full_d;
         resync_q   <= resync_d;
         line_ok_q  <= line_ok_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         blank_q    <= blank_d;
         color_q    <= color_d;
         underrun_q <= underrun_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // Line storage needs no reset: the full flags gate every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[wy_q[0]][wx_q] <= in_color;
      end
   end

   assign vga_hsync = hsync_q;
   assign vga_vsync = vsync_q;
   assign vga_blank = blank_q;
   assign vga_color = color_q;
   assign underrun  = underrun_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a reduced raster (8x4 active, 15x8 total) so
// whole frames fit in a short run. dut_a runs at CLK_DIV=1 for sync timing;
// dut_b runs at CLK_DIV=2 for reset, data path, backpressure, sequence error
// and underrun recovery.
module tb_vga_scanout;

   localparam int unsigned W  = 8;
   localparam int unsigned HT = 4;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals
   logic       reset_a, in_valid_a, in_ready_a;
   logic [2:0] in_x_a;
   logic [1:0] in_y_a;
   logic [7:0] in_color_a, vga_color_a;
   logic       vga_hsync_a, vga_vsync_a, vga_blank_a, underrun_a, seq_err_a;

   // dut_b signals
   logic       reset_b, in_valid_b, in_ready_b;
   logic [2:0] in_x_b;
   logic [1:0] in_y_b;
   logic [7:0] in_color_b, vga_color_b;
   logic       vga_hsync_b, vga_vsync_b, vga_blank_b, underrun_b, seq_err_b;

   vga_scanout #(
      .WIDTH(W), .HEIGHT(HT), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1), .COLOR_WIDTH(8)
   ) dut_a (
      .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_x(in_x_a), .in_y(in_y_a), .in_color(in_color_a),
      .vga_hsync(vga_hsync_a), .vga_vsync(vga_vsync_a), .vga_blank(vga_blank_a),
      .vga_color(vga_color_a), .underrun(underrun_a), .seq_err(seq_err_a)
   );

   vga_scanout #(
      .WIDTH(W), .HEIGHT(HT), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2), .COLOR_WIDTH(8)
   ) dut_b (
      .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_x(in_x_b), .in_y(in_y_b), .in_color(in_color_b),
      .vga_hsync(vga_hsync_b), .vga_vsync(vga_vsync_b), .vga_blank(vga_blank_b),
      .vga_color(vga_color_b), .underrun(underrun_b), .seq_err(seq_err_b)
   );

   int checks   = 0;
   int failures = 0;

   // Handshake seen at the most recent edge
   logic acc_b;
   always @(posedge clk) acc_b <= in_valid_b && in_ready_b;

   typedef struct {
      int   k;
      logic hs;
      logic vs;
      logic bl;
   } sync_vec_t;

   typedef struct {
      int         tick;
      logic       bl;
      logic [7:0] color;
   } pix_vec_t;

   sync_vec_t sync_tbl[$];
   pix_vec_t  pix_tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int x, input int y, input int c, output bit ok);
      in_valid_b = 1'b1;
      in_x_b     = 3'(x);
      in_y_b     = 2'(y);
      in_color_b = 8'(c);
      ok         = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (acc_b) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid_b = 1'b0;
   endtask

   initial begin
      int idx;
      int hs_low;
      int vs_low;
      int pidx;
      int nz;

      // Tick k after reset release shows h=k%15, v=(k/15)%8.
      // hsync low at h in [10,13); vsync low at v in [5,7); frame is 120 ticks.
      sync_tbl.push_back('{0,   1'b1, 1'b1, 1'b0});
      sync_tbl.push_back('{7,   1'b1, 1'b1, 1'b0});
      sync_tbl.push_back('{8,   1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{9,   1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{10,  1'b0, 1'b1, 1'b1});
      sync_tbl.push_back('{12,  1'b0, 1'b1, 1'b1});
      sync_tbl.push_back('{13,  1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{14,  1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{15,  1'b1, 1'b1, 1'b0});
      sync_tbl.push_back('{59,  1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{60,  1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{74,  1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{75,  1'b1, 1'b0, 1'b1});
      sync_tbl.push_back('{85,  1'b0, 1'b0, 1'b1});
      sync_tbl.push_back('{104, 1'b1, 1'b0, 1'b1});
      sync_tbl.push_back('{105, 1'b1, 1'b1, 1'b1});
      sync_tbl.push_back('{120, 1'b1, 1'b1, 1'b0});
      sync_tbl.push_back('{130, 1'b0, 1'b1, 1'b1});

      // Second frame of dut_b: pixel (x,y) at tick 120+y*15+x carries x+y*8;
      // h==8 is the first blanked column.
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x <= 8; x++) begin
            if (x < 8) pix_tbl.push_back('{120 + y * 15 + x, 1'b0, 8'(x + y * 8)});
            else       pix_tbl.push_back('{120 + y * 15 + x, 1'b1, 8'h00});
         end
      end
      pix_tbl.push_back('{180, 1'b1, 8'h00});

      reset_a    = 1'b1;
      reset_b    = 1'b1;
      in_valid_a = 1'b0;
      in_x_a     = '0;
      in_y_a     = '0;
      in_color_a = '0;
      in_valid_b = 1'b0;
      in_x_b     = '0;
      in_y_b     = '0;
      in_color_b = '0;

      // ---------------- sync timing, CLK_DIV=1 ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_a = 1'b0;
      idx     = 0;
      hs_low  = 0;
      vs_low  = 0;
      for (int k = 0; k < 132; k++) begin
         @(posedge clk);
         #1;
         if (k < 120) begin
            hs_low += (vga_hsync_a == 1'b0) ? 1 : 0;
            vs_low += (vga_vsync_a == 1'b0) ? 1 : 0;
         end
         if (k == 0) check("a_underrun_first_line", underrun_a, 1);
         if (idx < sync_tbl.size() && sync_tbl[idx].k == k) begin
            check($sformatf("a_hsync_t%0d", k), vga_hsync_a, sync_tbl[idx].hs);
            check($sformatf("a_vsync_t%0d", k), vga_vsync_a, sync_tbl[idx].vs);
            check($sformatf("a_blank_t%0d", k), vga_blank_a, sync_tbl[idx].bl);
            idx++;
         end
      end
      check("a_hsync_low_ticks_per_frame", hs_low, 24);
      check("a_vsync_low_ticks_per_frame", vs_low, 30);

      // ---------------- dut_b reset values ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_b = 1'b0;
      #1;
      check("b_reset_hsync", vga_hsync_b, 1);
      check("b_reset_vsync", vga_vsync_b, 1);
      check("b_reset_blank", vga_blank_b, 1);
      check("b_reset_color", vga_color_b, 0);
      check("b_reset_underrun", underrun_b, 0);
      check("b_reset_seq_err", seq_err_b, 0);
      check("b_reset_in_ready", in_ready_b, 1);

      // Tick k of dut_b lands on edge 2k+1 after reset release.
      fork
         begin : display_side
            pidx = 0;
            nz   = 0;
            for (int e = 0; e <= 2 * 181; e++) begin
               @(posedge clk);
               #1;
               if (e == 1) begin
                  check("b_underrun_first_line", underrun_b, 1);
                  check("b_ready_low_in_resync", in_ready_b, 0);
                  check("b_seq_err_clear_initially", seq_err_b, 0);
               end
               if ((e % 2) == 1 && e < 240) nz += (vga_color_b != 8'h00) ? 1 : 0;
               if (e == 119) check("b_ready_low_before_resync_end", in_ready_b, 0);
               if (e == 121) check("b_ready_high_after_resync_end", in_ready_b, 1);
               if (e == 253) check("b_ready_low_before_bank0_clear", in_ready_b, 0);
               if (e == 255) check("b_ready_high_after_bank0_clear", in_ready_b, 1);
               if ((e % 2) == 1 && pidx < pix_tbl.size() && pix_tbl[pidx].tick == (e - 1) / 2)
               begin
                  check($sformatf("b_blank_t%0d", pix_tbl[pidx].tick), vga_blank_b,
                        pix_tbl[pidx].bl);
                  check($sformatf("b_color_t%0d", pix_tbl[pidx].tick), vga_color_b,
                        pix_tbl[pidx].color);
                  pidx++;
               end
            end
            check("b_frame0_nonzero_colors", nz, 0);
            check("b_frame1_vectors_reached", pidx, pix_tbl.size());
         end
         begin : write_side
            bit ok;
            int good;
            // Idle through the first lines of the frame before offering input.
            repeat (64) @(negedge clk);
            send(5, 0, 8'hFF, ok);
            check("b_bad_pixel_consumed", ok, 1);
            check("b_seq_err_set", seq_err_b, 1);
            good = 0;
            for (int y = 0; y < 4; y++) begin
               for (int x = 0; x < 8; x++) begin
                  send(x, y, x + y * 8, ok);
                  check($sformatf("b_accept_%0d_%0d", x, y), ok, 1);
                  good++;
                  if (good == 15) check("b_ready_after_15", in_ready_b, 1);
                  if (good == 16) check("b_ready_falls_after_16", in_ready_b, 0);
               end
            end
         end
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
